// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// One pipeline stage register with a skid buffer. in_ready comes directly
// from a flop, so upstream never sees a combinational path from out_ready.
// There are two storage slots:
//   main - drives the stage outputs
//   skid - holds the one extra entry that can arrive while main is stalled
//
// Optional feature:
//   PIPE_STAGE_PERF_CNT_EN - when defined, builds saturating 16-bit stall and
//                            bubble counters. When undefined, both counter
//                            ports are tied to zero.
//
// Parameters:
//   DATA_W - payload width. The payload is kept on bubble and on flush.
//   CTRL_W - control width. The control field is zero whenever its slot is
//            empty.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   in_valid    in   upstream entry present
//   in_ready    out  stage can accept an entry (registered)
//   in_ctrl     in   upstream control bits
//   in_data     in   upstream payload
//   flush       in   synchronous kill of every held entry
//   out_valid   out  output entry present
//   out_ready   in   downstream accepts the entry
//   out_ctrl    out  output control bits, forced to zero when out_valid=0
//   out_data    out  output payload (driven only from stored data)
//   stall_cnt   out  cycles with out_valid=1 and out_ready=0
//   bubble_cnt  out  cycles with out_valid=0
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt
);

  localparam int unsigned CNT_W = 16;

  // Main slot
  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;

  // Skid slot
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;

  logic              in_ready_q,   in_ready_d;

  logic              in_xfer;
  logic              main_free;

  assign in_xfer   = in_valid & in_ready_q;
  // Main can take a new entry this cycle if it is empty or being consumed.
  assign main_free = ~main_valid_q | out_ready;

  // Next-state logic for both slots and for in_ready
  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      // Flush kills every held entry and drops any incoming one.
      // Data fields keep their old values; only valid and ctrl are cleared.
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        // Drain the skid first to keep entry order. in_ready is low here,
        // so no input can arrive in the same cycle.
        main_valid_d = 1'b1;
        main_ctrl_d  = skid_ctrl_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = '0;
      end else if (in_xfer) begin
        main_valid_d = 1'b1;
        main_ctrl_d  = in_ctrl;
        main_data_d  = in_data;
      end else begin
        main_valid_d = 1'b0;
        main_ctrl_d  = '0;
      end
    end else if (in_xfer) begin
      // Main is stalled, so the entry in flight goes into the skid.
      skid_valid_d = 1'b1;
      skid_ctrl_d  = in_ctrl;
      skid_data_d  = in_data;
    end

    in_ready_d = ~skid_valid_d;
  end

  // Valid, ctrl and ready flops (asynchronous reset)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // Payload flops have no reset
  always_ff @(posedge clk) begin
    main_data_q <= main_data_d;
    skid_data_q <= skid_data_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_ctrl  = main_valid_q ? main_ctrl_q : '0;
  assign out_data  = main_data_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
  // Saturating performance counters
  logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (!main_valid_q && (bubble_cnt_q != {CNT_W{1'b1}}))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign stall_cnt  = CNT_W'(0);
  assign bubble_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed self-checking bench for pipe_stage_reg. Inputs are driven 1ns
// after each rising edge, and outputs are sampled at that same point.
// The expected counter values depend on PIPE_STAGE_PERF_CNT_EN.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 8;

`ifdef PIPE_STAGE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [15:0]       stall_cnt;
  logic [15:0]       bubble_cnt;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset values, sampled while reset is held
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    check("rst_bubble", 64'(bubble_cnt), 64'd0);

    // Release reset mid-cycle. in_ready should rise on the next edge.
    reset = 1'b0;
    step();
    check("rel_in_ready", 64'(in_ready), 64'd1);
    check("rel_out_valid", 64'(out_valid), 64'd0);

    // Counters: 2 bubbles, then 5 stalls, then a drain, then a 3rd bubble
    in_valid = 1'b1; in_data = 32'hDEAD; in_ctrl = 8'h5A;
    step();
    in_valid = 1'b0;
    check("cnt_out_data", 64'(out_data), 64'hDEAD);
    check("cnt_out_ctrl", 64'(out_ctrl), 64'h5A);
    repeat (5) step();
    check("cnt_stall5_held", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    step();
    check("cnt_stall", 64'(stall_cnt), PERF ? 64'd5 : 64'd0);
    check("cnt_bubble", 64'(bubble_cnt), PERF ? 64'd3 : 64'd0);

    // Streaming: data 0..9 with out_ready held high
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      in_ctrl  = 8'(i + 1);
      step();
      check($sformatf("strm_valid_%0d", i), 64'(out_valid), 64'd1);
      check($sformatf("strm_data_%0d", i), 64'(out_data), 64'(i));
      check($sformatf("strm_ctrl_%0d", i), 64'(out_ctrl), 64'(i + 1));
      check($sformatf("strm_rdy_%0d", i), 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    step();
    check("strm_end_valid", 64'(out_valid), 64'd0);
    check("strm_end_ctrl", 64'(out_ctrl), 64'd0);

    // Backpressure: A sits in main, B goes to the skid
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA0; in_ctrl = 8'h11;
    step();
    check("bp_a_data", 64'(out_data), 64'hA0);
    check("bp_a_rdy", 64'(in_ready), 64'd1);
    in_data = 32'hB0; in_ctrl = 8'h22;
    step();
    in_valid = 1'b0;
    check("bp_b_rdy", 64'(in_ready), 64'd0);
    check("bp_hold_a", 64'(out_data), 64'hA0);
    check("bp_hold_a_ctrl", 64'(out_ctrl), 64'h11);
    step();
    check("bp_stall_a", 64'(out_data), 64'hA0);
    check("bp_stall_rdy", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    step();
    check("bp_b_out_valid", 64'(out_valid), 64'd1);
    check("bp_b_out_data", 64'(out_data), 64'hB0);
    check("bp_b_out_ctrl", 64'(out_ctrl), 64'h22);
    check("bp_rdy_back", 64'(in_ready), 64'd1);
    step();
    check("bp_empty", 64'(out_valid), 64'd0);

    // Flush with a full skid and a simultaneous input C
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h1234; in_ctrl = 8'h33;
    step();
    in_data = 32'h5678; in_ctrl = 8'h44;
    step();
    check("fl_full_rdy", 64'(in_ready), 64'd0);
    flush = 1'b1; in_data = 32'hC0C0; in_ctrl = 8'h55;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_out_ctrl", 64'(out_ctrl), 64'd0);
    check("fl_out_data", 64'(out_data), 64'h1234);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) begin
      step();
      check("fl_no_c", 64'(out_valid), 64'd0);
    end

    // Flush while in_ready=1: the incoming entry D is discarded
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h77; in_ctrl = 8'h66;
    step();
    flush = 1'b1; in_data = 32'h99; in_ctrl = 8'h88;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl2_out_valid", 64'(out_valid), 64'd0);
    check("fl2_out_data", 64'(out_data), 64'h77);
    check("fl2_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    check("fl2_no_d", 64'(out_valid), 64'd0);

    // Async reset asserted mid-cycle while main and skid are both full
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hE1; in_ctrl = 8'h01;
    step();
    in_data = 32'hE2; in_ctrl = 8'h02;
    step();
    in_valid = 1'b0;
    check("ar_pre_valid", 64'(out_valid), 64'd1);
    #3;
    reset = 1'b1;
    #1;
    check("ar_out_valid", 64'(out_valid), 64'd0);
    check("ar_in_ready", 64'(in_ready), 64'd0);
    check("ar_out_ctrl", 64'(out_ctrl), 64'd0);
    check("ar_stall", 64'(stall_cnt), 64'd0);
    check("ar_bubble", 64'(bubble_cnt), 64'd0);
    step();
    check("ar_held_rdy", 64'(in_ready), 64'd0);
    #2;
    reset = 1'b0;
    step();
    check("ar_rel_rdy", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    check("ar_discard", 64'(out_valid), 64'd0);

`ifdef PIPE_STAGE_PERF_CNT_EN
    // Stall counter saturates and does not wrap
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hF00D; in_ctrl = 8'h0F;
    step();
    in_valid = 1'b0;
    repeat (70000) step();
    check("sat_stall", 64'(stall_cnt), 64'hFFFF);
    step();
    check("sat_stall_hold", 64'(stall_cnt), 64'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of the payload field; the payload is retained and never cleared by a bubble or flush.
REQ-002 Parameter CTRL_W, default 8: width of the control field; the control field is forced to zero whenever the stage holds no valid entry.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port in_valid  input  1: upstream entry present.
REQ-006 Port in_ready  output  1: stage can accept an entry; driven directly from a flop.
REQ-007 Port in_ctrl  input  CTRL_W: upstream control bits.
REQ-008 Port in_data  input  DATA_W: upstream payload (e.g. PC, operands).
REQ-009 Port flush  input  1: synchronous kill of every entry held in the stage.
REQ-010 Port out_valid  output  1: output entry present.
REQ-011 Port out_ready  input  1: downstream accepts the entry.
REQ-012 Port out_ctrl  output  CTRL_W: output control bits, zero when out_valid=0.
REQ-013 Port out_data  output  DATA_W: output payload.
REQ-014 Port stall_cnt  output  16: count of cycles with out_valid=1 and out_ready=0.
REQ-015 Port bubble_cnt  output  16: count of cycles with out_valid=0.

Function
REQ-016 Input handshake: a transfer occurs when in_valid=1 and in_ready=1.
REQ-017 Output handshake: a transfer occurs when out_valid=1 and out_ready=1.
REQ-018 Storage: two entries, main (drives the outputs) and skid (overflow), each holding valid, ctrl and data.
REQ-019 Latency: an entry accepted in cycle N appears on the outputs in cycle N+1 when main is empty or is draining in cycle N.
REQ-020 Throughput: one entry per cycle when out_ready is held at 1.
REQ-021 Main full, not draining, input transfer: the entry is written to skid, and in_ready goes to 0 in the next cycle.
REQ-022 Main draining with skid valid: skid moves to main, skid is cleared, in_ready returns to 1 in the next cycle, and no input is accepted in that cycle.
REQ-023 in_ready equals NOT skid_valid, registered.
REQ-024 Entry order is strictly preserved; no entry is dropped or duplicated except by flush.
REQ-025 Flush: the next state clears both valids, the stored ctrl fields and in_ready is forced to 1; data fields hold their previous values.
REQ-026 flush has priority over a simultaneous input transfer or output transfer: the incoming entry is discarded, while an output handshake in that same cycle still completes downstream.
REQ-027 out_ctrl is gated combinationally to zero whenever out_valid=0.
REQ-028 Data integrity: out_data reflects stored data only; it has no combinational path from in_data.

Reset
REQ-029 While reset=1, asynchronously: out_valid=0, skid valid=0, out_ctrl=0, the stored ctrl fields=0, in_ready=0.
REQ-030 The first rising clk edge after reset is released sets in_ready=1; data fields are not reset.
REQ-031 stall_cnt and bubble_cnt reset to 0; flush does not clear them.
REQ-032 Reset asserted mid-transfer discards all held entries with no partial update.

Configuration
REQ-033 Macro PIPE_STAGE_PERF_CNT_EN defined: stall_cnt and bubble_cnt each increment by 1 per qualifying cycle, saturate at 16'hFFFF and do not wrap.
REQ-034 Macro PIPE_STAGE_PERF_CNT_EN undefined: no counter logic is built; stall_cnt and bubble_cnt are tied to 16'h0000 and the ports remain present.

Verification
REQ-035 Streaming: reset, then in_valid=1 with out_ready=1 for 10 cycles, data 0..9 -> out_data 0..9 one cycle later, in order, with no gaps and in_ready constant at 1.
REQ-036 Backpressure: out_ready=0 while entries A, B are sent -> A held at the output, B in skid, in_ready=0; with out_ready=1 -> A then B emitted and in_ready=1 one cycle after B moves to main.
REQ-037 Flush with a full skid and simultaneous in_valid (entry C) -> next cycle out_valid=0, out_ctrl=0, out_data unchanged, in_ready=1, and C is never emitted.
REQ-038 Async reset asserted mid-cycle with entries held -> out_valid=0 and in_ready=0 before the next clk edge; in_ready=1 one edge after release.
REQ-039 Counters with PIPE_STAGE_PERF_CNT_EN: 5 stalled cycles and 3 empty cycles -> stall_cnt=5, bubble_cnt=3; after 70000 stalled cycles, stall_cnt=16'hFFFF; without the macro both read 0.
